// File: rtl/palette_loader.sv
// Palette table loaded from a slow serial port clocked asynchronously to clk.
// Each 9-bit frame carries {index, colour}; writes are deferred to vertical blanking.
module palette_loader #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_sclk,
    input  logic       cfg_sdata,
    input  logic       cfg_cs_n,
    input  logic       vblank,
    input  logic       defaults_req,
    input  logic [2:0] color_index,
    input  logic       white_background,
    output logic [5:0] rrggbb,
    output logic       busy,
    output logic       write_done,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        PENDING = 2'd2
    } state_t;

    localparam int SETTLE = SYNC_STAGES + 1;
    localparam int SW     = $clog2(SETTLE + 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE);

    function automatic logic [5:0] default_color(input logic [2:0] idx);
        logic [5:0] c;
        c = 6'b000000;
        case (idx)
            3'd0: c = 6'b001011;
            3'd1: c = 6'b110110;
            3'd2: c = 6'b101101;
            3'd3: c = 6'b111000;
            3'd4: c = 6'b110011;
            3'd5: c = 6'b111100;
            3'd6: c = 6'b110001;
            3'd7: c = 6'b111111;
            default: c = 6'b000000;
        endcase
        return c;
    endfunction

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] sdata_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sclk_d;
    logic                   cs_d;

    // Select idles high, so its chain resets to 1 to avoid a false falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync  <= '0;
            sdata_sync <= '0;
            cs_sync    <= '1;
            sclk_d     <= 1'b0;
            cs_d       <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
            sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], cfg_sclk};
            sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], cfg_sdata};
            cs_sync    <= {cs_sync[SYNC_STAGES-2:0], cfg_cs_n};
            sclk_d     <= sclk_sync[SYNC_STAGES-1];
            cs_d       <= cs_sync[SYNC_STAGES-1];
        end
    end

    logic sclk_s, sdata_s, cs_s;
    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign sdata_s = sdata_sync[SYNC_STAGES-1];
    assign cs_s    = cs_sync[SYNC_STAGES-1];

    // A frame already running when reset lifts must not be picked up half-way:
    // only arm once the chain has flushed and the select is genuinely seen high.
    logic [SW-1:0] settle_cnt;
    logic          armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_cnt <= '0;
            armed      <= 1'b0;
        end else if (settle_cnt != SETTLE_MAX) begin
            settle_cnt <= settle_cnt + 1'b1;
        end else if (cs_s) begin
            armed <= 1'b1;
        end
    end

    logic sclk_rise, cs_fall, cs_rise;
    assign sclk_rise = sclk_s & ~sclk_d;
    assign cs_fall   = armed & ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    state_t     state;
    logic [8:0] shift_reg;
    logic [3:0] bit_cnt;
    logic [2:0] pend_idx;
    logic [5:0] pend_col;
    logic [5:0] pal_q [8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            pend_idx   <= '0;
            pend_col   <= '0;
            write_done <= 1'b0;
            frame_err  <= 1'b0;
            // NOTE: the palette is a small register array with defined power-up
            // contents, so it is reset here rather than left to a RAM.
            for (int i = 0; i < 8; i++) pal_q[i] <= default_color(3'(i));
        end else begin
            write_done <= 1'b0;
            frame_err  <= 1'b0;

            if (defaults_req) begin
                for (int i = 0; i < 8; i++) pal_q[i] <= default_color(3'(i));
            end

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state     <= SHIFT;
                        shift_reg <= '0;
                        bit_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        if (bit_cnt == 4'd9) begin
                            pend_idx <= shift_reg[8:6];
                            pend_col <= shift_reg[5:0];
                            state    <= PENDING;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= IDLE;
                        end
                    end else if (sclk_rise) begin
                        shift_reg <= {shift_reg[7:0], sdata_s};
                        bit_cnt   <= (bit_cnt == 4'd10) ? bit_cnt : bit_cnt + 4'd1;
                    end
                end
                PENDING: begin
                    // A coincident defaults reload takes the cycle; the write retries.
                    if (vblank && !defaults_req) begin
                        pal_q[pend_idx] <= pend_col;
                        write_done      <= 1'b1;
                        state           <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy   = (state == SHIFT) || (state == PENDING);
    assign rrggbb = (color_index == 3'd7 && white_background) ? 6'b000000 : pal_q[color_index];

endmodule

// File: tb/tb_palette_loader.sv
// Self-checking bench for palette_loader: read-port vector table, scoreboard of
// expected write_done / frame_err events, and hand-written corner sequences.
module tb_palette_loader;

    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 4;

    logic       clk;
    logic       rst_n;
    logic       cfg_sclk;
    logic       cfg_sdata;
    logic       cfg_cs_n;
    logic       vblank;
    logic       defaults_req;
    logic [2:0] color_index;
    logic       white_background;
    logic [5:0] rrggbb;
    logic       busy;
    logic       write_done;
    logic       frame_err;

    palette_loader #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_sclk         (cfg_sclk),
        .cfg_sdata        (cfg_sdata),
        .cfg_cs_n         (cfg_cs_n),
        .vblank           (vblank),
        .defaults_req     (defaults_req),
        .color_index      (color_index),
        .white_background (white_background),
        .rrggbb           (rrggbb),
        .busy             (busy),
        .write_done       (write_done),
        .frame_err        (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {EV_WRITE, EV_ERR} ev_kind_t;
    typedef struct {
        ev_kind_t   kind;
        logic [2:0] idx;
        logic [5:0] col;
    } ev_t;

    typedef struct {
        logic [2:0] idx;
        logic       wb;
        logic [5:0] exp;
    } rd_vec_t;

    ev_t        sb_q[$];
    logic [5:0] model [8];
    int         n_tests  = 0;
    int         n_fail   = 0;
    int         n_writes = 0;
    int         n_errs   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic reset_model();
        model = '{6'b001011, 6'b110110, 6'b101101, 6'b111000,
                  6'b110011, 6'b111100, 6'b110001, 6'b111111};
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bits(input logic [9:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            cfg_sdata = bits[i];
            cycles(HALF);
            cfg_sclk = 1'b1;
            cycles(HALF);
            cfg_sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [9:0] bits, input int n);
        cfg_cs_n = 1'b0;
        cycles(HALF);
        shift_bits(bits, n);
        cycles(HALF);
        cfg_cs_n = 1'b1;
        cycles(HALF);
    endtask

    task automatic read_check(input string name, input logic [2:0] idx, input logic wb,
                              input logic [5:0] exp);
        color_index      = idx;
        white_background = wb;
        #1;
        check(name, rrggbb, exp);
    endtask

    task automatic wait_events(input int budget);
        int left;
        left = budget;
        while (sb_q.size() != 0 && left > 0) begin
            @(negedge clk);
            left--;
        end
        check("scoreboard drained", sb_q.size(), 0);
    endtask

    task automatic push_ev(input ev_kind_t k, input logic [2:0] idx, input logic [5:0] col);
        ev_t e;
        e.kind = k;
        e.idx  = idx;
        e.col  = col;
        sb_q.push_back(e);
    endtask

    // Every output pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        ev_t e;
        if (rst_n && (write_done || frame_err)) begin
            if (write_done) n_writes++;
            if (frame_err)  n_errs++;
            if (sb_q.size() == 0) begin
                check("unexpected pulse", {30'd0, write_done, frame_err}, 0);
            end else begin
                e = sb_q.pop_front();
                check("pulse kind", {30'd0, write_done, frame_err},
                      (e.kind == EV_WRITE) ? 32'd2 : 32'd1);
                if (e.kind == EV_WRITE && write_done) model[e.idx] = e.col;
            end
        end
    end

    initial begin : watchdog
        #500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rd_vec_t vecs [9];
        int      w0, e0;

        vecs[0] = '{3'd0, 1'b0, 6'b001011};
        vecs[1] = '{3'd1, 1'b0, 6'b110110};
        vecs[2] = '{3'd2, 1'b0, 6'b101101};
        vecs[3] = '{3'd3, 1'b0, 6'b111000};
        vecs[4] = '{3'd4, 1'b0, 6'b110011};
        vecs[5] = '{3'd5, 1'b0, 6'b111100};
        vecs[6] = '{3'd6, 1'b0, 6'b110001};
        vecs[7] = '{3'd7, 1'b0, 6'b111111};
        vecs[8] = '{3'd7, 1'b1, 6'b000000};

        rst_n            = 1'b0;
        cfg_sclk         = 1'b0;
        cfg_sdata        = 1'b0;
        cfg_cs_n         = 1'b1;
        vblank           = 1'b0;
        defaults_req     = 1'b0;
        color_index      = 3'd0;
        white_background = 1'b0;
        reset_model();

        cycles(3);
        check("reset busy", busy, 0);
        check("reset write_done", write_done, 0);
        check("reset frame_err", frame_err, 0);
        rst_n = 1'b1;
        cycles(SYNC_STAGES + 6);

        // Default table through the read port.
        for (int i = 0; i < 9; i++) begin
            read_check($sformatf("default idx%0d wb%0d", vecs[i].idx, vecs[i].wb),
                       vecs[i].idx, vecs[i].wb, vecs[i].exp);
        end

        // Write held off while vblank is low.
        push_ev(EV_WRITE, 3'd3, 6'b000111);
        w0 = n_writes;
        send_frame(10'b0_011_000111, 9);
        cycles(20);
        check("held busy", busy, 1);
        check("held no write", n_writes, w0);
        read_check("held idx3", 3'd3, 1'b0, 6'b111000);
        vblank = 1'b1;
        wait_events(10);
        check("one write", n_writes, w0 + 1);
        read_check("written idx3", 3'd3, 1'b0, 6'b000111);
        cycles(1);
        check("idle after write", busy, 0);
        vblank = 1'b0;

        // Short and long frames are rejected, even with vblank open.
        vblank = 1'b1;
        w0 = n_writes;
        e0 = n_errs;
        push_ev(EV_ERR, 3'd0, 6'd0);
        send_frame(10'b00_1010_0101, 8);
        wait_events(20);
        push_ev(EV_ERR, 3'd0, 6'd0);
        send_frame(10'b11_0000_1111, 10);
        wait_events(20);
        check("two frame_err", n_errs, e0 + 2);
        check("no write on bad frame", n_writes, w0);
        for (int i = 0; i < 8; i++) begin
            read_check($sformatf("after err idx%0d", i), 3'(i), 1'b0, model[i]);
        end

        // Write to index 7 with vblank already high, then white background masking.
        push_ev(EV_WRITE, 3'd7, 6'b010101);
        send_frame(10'b0_111_010101, 9);
        wait_events(20);
        read_check("idx7 wb0", 3'd7, 1'b0, 6'b010101);
        read_check("idx7 wb1", 3'd7, 1'b1, 6'b000000);
        white_background = 1'b0;
        vblank = 1'b0;

        // Defaults reload collides with the pending write to index 2.
        w0 = n_writes;
        send_frame(10'b0_010_101010, 9);
        cycles(4);
        check("pending busy", busy, 1);
        vblank       = 1'b1;
        defaults_req = 1'b1;
        cycles(1);
        defaults_req = 1'b0;
        vblank       = 1'b0;
        reset_model();
        check("collision no write", n_writes, w0);
        check("collision still pending", busy, 1);
        read_check("restored idx3", 3'd3, 1'b0, 6'b111000);
        read_check("restored idx7", 3'd7, 1'b0, 6'b111111);
        read_check("restored idx2", 3'd2, 1'b0, 6'b101101);
        push_ev(EV_WRITE, 3'd2, 6'b101010);
        cycles(3);
        vblank = 1'b1;
        wait_events(10);
        read_check("late write idx2", 3'd2, 1'b0, 6'b101010);
        vblank = 1'b0;

        // Reset after 5 of 9 bits; the rest of the stale frame must be ignored.
        vblank   = 1'b1;
        cfg_cs_n = 1'b0;
        cycles(HALF);
        shift_bits(10'b00000_10101, 5);
        check("mid-frame busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("reset busy async", busy, 0);
        check("reset write_done async", write_done, 0);
        reset_model();
        cycles(3);
        rst_n = 1'b1;
        w0 = n_writes;
        e0 = n_errs;
        shift_bits(10'b000000_1011, 4);
        cycles(HALF);
        cfg_cs_n = 1'b1;
        cycles(20);
        check("stale no write", n_writes, w0);
        check("stale no frame_err", n_errs, e0);
        check("stale busy", busy, 0);
        read_check("stale idx5", 3'd5, 1'b0, model[5]);
        read_check("reset idx2", 3'd2, 1'b0, model[2]);
        push_ev(EV_WRITE, 3'd5, 6'b100100);
        send_frame(10'b0_101_100100, 9);
        wait_events(20);
        read_check("fresh idx5", 3'd5, 1'b0, 6'b100100);
        vblank = 1'b0;

        cycles(5);
        check("scoreboard empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
